// File: rtl/station_ctrl.sv
// station_ctrl: sequencing controller for the line follower's barcode reader and
// drive enable. Accepts GO/STOP commands, consumes station IDs, stops and buzzes
// on reaching the commanded station, and aborts the run on a watchdog expiry.
module station_ctrl #(
    parameter int unsigned TIMEOUT  = 50_000_000,
    parameter int unsigned BUZZ_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    output logic       go,
    output logic       buzz,
    output logic       arrived,
    output logic       timeout,
    output logic [5:0] last_stn
);

    localparam int unsigned TMO_W  = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam int unsigned BUZZ_W = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;
    localparam int unsigned STN_W  = 6;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_CHECK  = 2'd2,
        ST_BUZZ   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [STN_W-1:0]  dest_q, dest_d;
    logic [STN_W-1:0]  last_stn_q, last_stn_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic              go_q, go_d;
    logic              buzz_q, buzz_d;
    logic              arrived_q, arrived_d;
    logic              timeout_q, timeout_d;

    logic              cmd_go;
    logic              cmd_stop;
    logic              tmo_expired;
    logic              buzz_done;
    logic              stn_match;
    logic [TMO_W-1:0]  tmo_cnt_inc;

    // ID[7:6] is guaranteed zero by the reader and deliberately ignored.
    logic unused_id_hi;
    assign unused_id_hi = ^ID[7:6];

    // Command decode and counter/compare helpers shared by both comb processes.
    always_comb begin
        cmd_go      = (cmd[7:6] == OP_GO);
        cmd_stop    = (cmd[7:6] == OP_STOP);
        tmo_expired = (tmo_cnt_q == TMO_LAST);
        buzz_done   = (buzz_cnt_q == BUZZ_LAST);
        stn_match   = (last_stn_q == dest_q);
        tmo_cnt_inc = (tmo_cnt_q == {TMO_W{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pending command always wins over a pending station ID.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_rdy && cmd_go) begin
                    state_d = ST_MOVING;
                end
            end
            ST_MOVING: begin
                if (cmd_rdy) begin
                    if (cmd_stop) begin
                        state_d = ST_IDLE;
                    end
                end else if (ID_vld) begin
                    state_d = ST_CHECK;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                state_d = stn_match ? ST_BUZZ : ST_MOVING;
            end
            ST_BUZZ: begin
                if (buzz_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-values: Mealy acknowledges plus register updates.
    always_comb begin
        clr_cmd_rdy = 1'b0;
        clr_ID_vld  = 1'b0;
        dest_d      = dest_q;
        last_stn_d  = last_stn_q;
        tmo_cnt_d   = tmo_cnt_q;
        buzz_cnt_d  = buzz_cnt_q;
        arrived_d   = arrived_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    if (cmd_go) begin
                        dest_d    = cmd[5:0];
                        tmo_cnt_d = '0;
                        arrived_d = 1'b0;
                        timeout_d = 1'b0;
                    end
                end else if (ID_vld) begin
                    clr_ID_vld = 1'b1;
                    last_stn_d = ID[5:0];
                end
            end
            ST_MOVING: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    if (cmd_go) begin
                        dest_d    = cmd[5:0];
                        tmo_cnt_d = '0;
                    end
                end else if (ID_vld) begin
                    clr_ID_vld = 1'b1;
                    last_stn_d = ID[5:0];
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                end
            end
            ST_CHECK: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (stn_match) begin
                    arrived_d  = 1'b1;
                    buzz_cnt_d = '0;
                end
            end
            ST_BUZZ: begin
                buzz_cnt_d = buzz_cnt_q + BUZZ_W'(1);
            end
            default: ;
        endcase
        // No handshake pulses may escape while reset is held.
        if (rst) begin
            clr_cmd_rdy = 1'b0;
            clr_ID_vld  = 1'b0;
        end
        go_d   = (state_d == ST_MOVING) || (state_d == ST_CHECK);
        buzz_d = (state_d == ST_BUZZ);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q     <= '0;
            last_stn_q <= '0;
            tmo_cnt_q  <= '0;
            buzz_cnt_q <= '0;
            go_q       <= 1'b0;
            buzz_q     <= 1'b0;
            arrived_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            dest_q     <= dest_d;
            last_stn_q <= last_stn_d;
            tmo_cnt_q  <= tmo_cnt_d;
            buzz_cnt_q <= buzz_cnt_d;
            go_q       <= go_d;
            buzz_q     <= buzz_d;
            arrived_q  <= arrived_d;
            timeout_q  <= timeout_d;
        end
    end

    assign go       = go_q;
    assign buzz     = buzz_q;
    assign arrived  = arrived_q;
    assign timeout  = timeout_q;
    assign last_stn = last_stn_q;

endmodule

// File: tb/tb_station_ctrl.sv
// tb_station_ctrl: directed test-plan sequences followed by randomized traffic,
// all checked every cycle against a behavioural model of the controller.
module tb_station_ctrl;

    localparam int unsigned TIMEOUT  = 100;
    localparam int unsigned BUZZ_CYC = 8;
    localparam int TMO_MAX = (1 << $clog2(TIMEOUT)) - 1;
    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cmd = 8'h00;
    logic       cmd_rdy = 1'b0;
    logic [7:0] ID = 8'h00;
    logic       ID_vld = 1'b0;
    logic       clr_cmd_rdy, clr_ID_vld, go, buzz, arrived, timeout;
    logic [5:0] last_stn;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    station_ctrl #(.TIMEOUT(TIMEOUT), .BUZZ_CYC(BUZZ_CYC)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .go(go), .buzz(buzz),
        .arrived(arrived), .timeout(timeout), .last_stn(last_stn)
    );

    // Behavioural model: a run (drive on), an optional one-cycle station check
    // inside the run, and a buzzer countdown after a successful arrival.
    bit         m_run = 0;
    bit         m_chk = 0;
    int         m_buzz_left = 0;
    int         m_elapsed = 0;
    int         el_next;
    logic [5:0] m_dest = '0;
    logic [5:0] m_last = '0;
    bit         m_arr = 0;
    bit         m_tmo = 0;

    function automatic bit m_idle();
        return !m_run && (m_buzz_left == 0);
    endfunction

    function automatic bit m_listening();
        return m_idle() || (m_run && !m_chk);
    endfunction

    function automatic bit exp_clr_cmd();
        return !rst && cmd_rdy && m_listening();
    endfunction

    function automatic bit exp_clr_id();
        return !rst && ID_vld && !cmd_rdy && m_listening();
    endfunction

    // Model update at each clock (or immediately on reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_chk = 0; m_buzz_left = 0; m_elapsed = 0;
            m_dest = '0; m_last = '0; m_arr = 0; m_tmo = 0;
        end else if (m_idle()) begin
            if (cmd_rdy) begin
                if (cmd[7:6] == OP_GO) begin
                    m_dest = cmd[5:0]; m_elapsed = 0; m_arr = 0; m_tmo = 0; m_run = 1;
                end
            end else if (ID_vld) begin
                m_last = ID[5:0];
            end
        end else if (m_run && !m_chk) begin
            el_next = (m_elapsed < TMO_MAX) ? m_elapsed + 1 : m_elapsed;
            if (cmd_rdy) begin
                if (cmd[7:6] == OP_STOP) begin
                    m_run = 0;
                end else if (cmd[7:6] == OP_GO) begin
                    m_dest = cmd[5:0];
                    el_next = 0;
                end
            end else if (ID_vld) begin
                m_last = ID[5:0];
                m_chk = 1;
            end else if (m_elapsed == int'(TIMEOUT) - 1) begin
                m_tmo = 1;
                m_run = 0;
            end
            m_elapsed = el_next;
        end else if (m_chk) begin
            m_elapsed = (m_elapsed < TMO_MAX) ? m_elapsed + 1 : m_elapsed;
            m_chk = 0;
            if (m_last == m_dest) begin
                m_arr = 1;
                m_run = 0;
                m_buzz_left = BUZZ_CYC;
            end
        end else begin
            m_buzz_left = m_buzz_left - 1;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("clr_cmd_rdy", 8'(clr_cmd_rdy), 8'(exp_clr_cmd()));
        chk("clr_ID_vld",  8'(clr_ID_vld),  8'(exp_clr_id()));
        chk("go",          8'(go),          8'(m_run));
        chk("buzz",        8'(buzz),        8'(m_buzz_left > 0));
        chk("arrived",     8'(arrived),     8'(m_arr));
        chk("timeout",     8'(timeout),     8'(m_tmo));
        chk("last_stn",    8'(last_stn),    8'(m_last));
    end

    // One clock: capture acknowledges mid-cycle, drop acknowledged flags after the edge.
    task automatic tick();
        logic ack_c, ack_i;
        @(negedge clk);
        ack_c = clr_cmd_rdy;
        ack_i = clr_ID_vld;
        @(posedge clk);
        #1;
        if (ack_c) cmd_rdy = 1'b0;
        if (ack_i) ID_vld = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] d);
        cmd = {op, d};
        cmd_rdy = 1'b1;
    endtask

    task automatic send_id(input logic [5:0] s);
        ID = {2'b00, s};
        ID_vld = 1'b1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_go", 8'(go), 8'h0);
        chk("rst_buzz", 8'(buzz), 8'h0);
        chk("rst_arrived", 8'(arrived), 8'h0);
        chk("rst_timeout", 8'(timeout), 8'h0);
        chk("rst_last_stn", 8'(last_stn), 8'h0);

        // GO to 0x15, pass station 0x03, arrive at 0x15.
        send_cmd(OP_GO, 6'h15);
        tick();
        chk("go_after_go", 8'(go), 8'h1);
        send_id(6'h03);
        tick();
        tick();
        chk("go_through_03", 8'(go), 8'h1);
        send_id(6'h15);
        tick();
        tick();
        chk("arr_go", 8'(go), 8'h0);
        chk("arr_buzz", 8'(buzz), 8'h1);
        chk("arr_arrived", 8'(arrived), 8'h1);
        chk("arr_last_stn", 8'(last_stn), 8'h15);
        n = 0;
        while (buzz && n < 20) begin n++; tick(); end
        chk("buzz_len", 8'(n), 8'(BUZZ_CYC));

        // GO to 0x0A with no station: watchdog.
        send_cmd(OP_GO, 6'h0A);
        tick();
        n = 0;
        while (go && n < 200) begin n++; tick(); end
        chk("tmo_cycles", 8'(n), 8'(TIMEOUT));
        chk("tmo_flag", 8'(timeout), 8'h1);
        send_cmd(OP_GO, 6'h30);
        tick();
        chk("rego_timeout", 8'(timeout), 8'h0);
        chk("rego_go", 8'(go), 8'h1);

        // STOP after 20 cycles of motion.
        repeat (20) tick();
        send_cmd(OP_STOP, 6'h00);
        tick();
        chk("stop_go", 8'(go), 8'h0);
        chk("stop_arrived", 8'(arrived), 8'h0);

        // Command and matching station ID presented together while moving.
        send_cmd(OP_GO, 6'h22);
        tick();
        send_cmd(OP_GO, 6'h22);
        send_id(6'h22);
        tick();
        chk("both_cmd_acked", 8'(cmd_rdy), 8'h0);
        chk("both_id_pending", 8'(ID_vld), 8'h1);
        tick();
        chk("both_id_acked", 8'(ID_vld), 8'h0);
        tick();
        chk("both_arrived", 8'(arrived), 8'h1);

        // GO issued during buzz waits until idle.
        send_cmd(OP_GO, 6'h05);
        repeat (3) tick();
        chk("buzz_cmd_pending", 8'(cmd_rdy), 8'h1);
        n = 0;
        while (buzz && n < 20) begin n++; tick(); end
        tick();
        chk("post_buzz_go", 8'(go), 8'h1);

        // Reset pulse in the middle of a buzz.
        send_id(6'h05);
        repeat (4) tick();
        chk("pre_rst_buzz", 8'(buzz), 8'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_buzz", 8'(buzz), 8'h0);
        chk("rst_async_go", 8'(go), 8'h0);
        chk("rst_async_arrived", 8'(arrived), 8'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rel_go", 8'(go), 8'h0);
        chk("rst_rel_last_stn", 8'(last_stn), 8'h0);
        tick();

        // Randomized traffic; the second half rarely reports stations so the watchdog fires.
        for (int i = 0; i < 4000; i++) begin
            if (!cmd_rdy && $urandom_range(0, 5) == 0)
                send_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)));
            if (!ID_vld && $urandom_range(0, (i < 2000) ? 2 : 60) == 0)
                send_id(6'($urandom_range(0, 7)));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
